// File: rtl/sensor_cond.sv
// Crank-sensor conditioning: debounces the cadence pulse, counts pulses per
// fixed window, flags "not pedaling", and keeps an exponential moving average
// of torque that is stepped once per accepted crank pulse.
module sensor_cond #(
  parameter int FAST_SIM = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] torque,
  input  logic        cadence_raw,
  output logic [11:0] avg_torque,
  output logic [4:0]  cadence,
  output logic        not_pedaling,
  output logic        cadence_rise
);

  // Window length is 2^WIN_BITS clocks; the short window only exists so that
  // simulations see several windows in a reasonable number of cycles.
  localparam int WIN_BITS = (FAST_SIM != 0) ? 12 : 22;

  logic                sync1;
  logic                sync2;
  logic                cad_filt;
  logic                cad_filt_d;
  logic [3:0]          stab_cnt;
  logic [WIN_BITS-1:0] win_timer;
  logic                win_end;
  logic [4:0]          pulse_cnt;
  logic [15:0]         acc;
  logic [15:0]         acc_step;
  logic                np_fall;

  // Two-flop synchronizer; nothing downstream looks at cadence_raw directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= cadence_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the filtered level follows the input only after 16 consecutive
  // clocks of disagreement; any agreeing clock restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cad_filt <= 1'b0;
      stab_cnt <= 4'd0;
    end else if (sync2 == cad_filt) begin
      stab_cnt <= 4'd0;
    end else if (stab_cnt == 4'd15) begin
      cad_filt <= ~cad_filt;
      stab_cnt <= 4'd0;
    end else begin
      stab_cnt <= stab_cnt + 4'd1;
    end
  end

  // One-clock strobe in the clock after the filtered level rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cad_filt_d   <= 1'b0;
      cadence_rise <= 1'b0;
    end else begin
      cad_filt_d   <= cad_filt;
      cadence_rise <= cad_filt & ~cad_filt_d;
    end
  end

  // Free-running window timer; the all-ones value closes the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_timer <= '0;
    end else begin
      win_timer <= win_timer + 1'b1;
    end
  end

  assign win_end = &win_timer;

  // Pulse counting per window. A strobe landing on the closing clock belongs
  // to the window that is just starting, so the new count starts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt <= 5'd0;
      cadence   <= 5'd0;
    end else if (win_end) begin
      cadence   <= pulse_cnt;
      pulse_cnt <= cadence_rise ? 5'd1 : 5'd0;
    end else if (cadence_rise && (pulse_cnt != 5'd31)) begin
      pulse_cnt <= pulse_cnt + 5'd1;
    end
  end

  // Rider is treated as stopped when fewer than two pulses landed in the last
  // window; registered one clock behind the cadence load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      not_pedaling <= 1'b1;
    end else begin
      not_pedaling <= (cadence < 5'd2);
    end
  end

  // acc holds 16x the average. acc - acc/16 + torque never exceeds 16 bits:
  // at acc = 0xFFFF the subtraction removes 0xFFF, which is >= any torque.
  assign acc_step = acc - {4'd0, acc[15:4]} + {4'd0, torque};
  // not_pedaling is about to fall exactly when it is high and cadence >= 2.
  assign np_fall  = not_pedaling && (cadence >= 5'd2);

  // Average update: preload on resuming pedaling so the filter does not ramp
  // from a stale value, step once per crank pulse, freeze while stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 16'd0;
    end else if (np_fall) begin
      acc <= {torque, 4'd0};
    end else if (cadence_rise && !not_pedaling) begin
      acc <= acc_step;
    end
  end

  assign avg_torque = acc[15:4];

endmodule

// File: tb/tb_sensor_cond.sv
// Bench for sensor_cond with the short window (4096 clocks). A reference
// model tracks expected strobes, window counts, pedaling flag and average
// from the stimulus schedule alone.
module tb_sensor_cond;

  localparam int WIN = 4096;
  localparam int LAT = 20;  // from the negedge raising raw to the edge where the strobe is consumed

  logic        clk;
  logic        rst;
  logic [11:0] torque;
  logic        cadence_raw;
  logic [11:0] avg_torque;
  logic [4:0]  cadence;
  logic        not_pedaling;
  logic        cadence_rise;

  int tot = 0;
  int bad = 0;

  sensor_cond #(.FAST_SIM(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .torque       (torque),
    .cadence_raw  (cadence_raw),
    .avg_torque   (avg_torque),
    .cadence      (cadence),
    .not_pedaling (not_pedaling),
    .cadence_rise (cadence_rise)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int cyc;       // posedges since reset release
  int sq[$];     // edges at which an accepted strobe is consumed
  int m_pulse;   // strobes seen in the current window (unsaturated)
  int m_cad;
  int m_np;
  int m_acc;

  always @(posedge clk) begin
    int strobe;
    int cad_old;
    int np_old;
    if (rst) begin
      cyc = 0; m_pulse = 0; m_cad = 0; m_np = 1; m_acc = 0;
      sq.delete();
    end else begin
      cyc++;
      strobe = 0;
      if (sq.size() > 0 && sq[0] == cyc) begin
        strobe = 1;
        void'(sq.pop_front());
      end
      cad_old = m_cad;
      np_old  = m_np;
      if (np_old == 1 && cad_old >= 2) m_acc = int'(torque) * 16;
      else if (strobe == 1 && np_old == 0) m_acc = m_acc - m_acc / 16 + int'(torque);
      m_np = (cad_old < 2) ? 1 : 0;
      if (cyc % WIN == 0) begin
        m_cad   = (m_pulse > 31) ? 31 : m_pulse;
        m_pulse = strobe;
      end else begin
        m_pulse = m_pulse + strobe;
      end
    end
  end

  // Strobe watcher: cadence_rise must be high exactly in the clock before the
  // edge that consumes a scheduled strobe, and never otherwise.
  int rise_err = 0;
  always @(negedge clk) begin
    logic exp_rise;
    exp_rise = 1'b0;
    if (!rst && sq.size() > 0 && sq[0] == cyc + 1) exp_rise = 1'b1;
    if (cadence_rise !== exp_rise) rise_err++;
  end

  // Monotonic watcher for the step response.
  logic        mono_en = 1'b0;
  logic [11:0] mono_prev = 12'd0;
  int          mono_err = 0;
  always @(negedge clk) begin
    if (mono_en) begin
      if (avg_torque < mono_prev) mono_err++;
      mono_prev = avg_torque;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cadence_raw = 1'b0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    cadence_raw = 1'b1;
    sq.push_back(cyc + LAT);
    step(hi);
    cadence_raw = 1'b0;
    step(lo);
  endtask

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    tot++;
    if (cyc != target) begin
      bad++;
      $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int base;
    rst = 1'b1;
    torque = 12'($urandom_range(0, 4095));
    base = rise_err;
    for (int i = 0; i < 20; i++) begin
      cadence_raw = 1'($urandom_range(0, 1));
      step(1);
    end
    tot++; if (cadence !== 5'd0) begin bad++; $display("FAIL rst_cadence: got %0d want 0", cadence); end
    tot++; if (not_pedaling !== 1'b1) begin bad++; $display("FAIL rst_np: got %b want 1", not_pedaling); end
    tot++; if (avg_torque !== 12'h000) begin bad++; $display("FAIL rst_avg: got %h want 000", avg_torque); end
    cadence_raw = 1'b0;
    rst = 1'b0;
    step(200);
    tot++; if (cadence !== 5'd0) begin bad++; $display("FAIL rel_cadence: got %0d want 0", cadence); end
    tot++; if (not_pedaling !== 1'b1) begin bad++; $display("FAIL rel_np: got %b want 1", not_pedaling); end
    tot++; if (avg_torque !== 12'h000) begin bad++; $display("FAIL rel_avg: got %h want 000", avg_torque); end
    tot++; if (rise_err !== base) begin bad++; $display("FAIL rst_rise: %0d unexpected strobe clocks, want 0", rise_err - base); end
  endtask

  task automatic test_first_window();
    int n;
    int base;
    do_reset();
    base = rise_err;
    torque = 12'($urandom_range(256, 4095));
    step(5);
    cadence_raw = 1'b1;
    sq.push_back(cyc + LAT);
    n = 0;
    while (cadence_rise !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tot++; if (n < 18 || n > 20) begin bad++; $display("FAIL latency: got %0d clocks want 18..20", n); end
    step(40 - n);
    cadence_raw = 1'b0;
    step(40);
    for (int i = 0; i < 3; i++) pulse(40, 40);
    wait_cyc(WIN - 1);
    tot++; if (cadence !== 5'd0) begin bad++; $display("FAIL win_pre: got %0d want 0", cadence); end
    step(1);
    tot++; if (cadence !== 5'd4) begin bad++; $display("FAIL win_load: got %0d want 4", cadence); end
    tot++; if (not_pedaling !== 1'b1) begin bad++; $display("FAIL np_hold: got %b want 1", not_pedaling); end
    step(1);
    tot++; if (not_pedaling !== 1'b0) begin bad++; $display("FAIL np_fall: got %b want 0", not_pedaling); end
    tot++; if (avg_torque !== torque) begin bad++; $display("FAIL preload: got %h want %h", avg_torque, torque); end
    tot++; if (rise_err !== base) begin bad++; $display("FAIL first_rise: %0d bad strobe clocks, want 0", rise_err - base); end
  endtask

  task automatic test_glitch();
    int base;
    do_reset();
    base = rise_err;
    torque = 12'h555;
    while (cyc < 2000) begin
      cadence_raw = 1'b1; step(10);
      cadence_raw = 1'b0; step(20);
    end
    while (cyc < 4000) begin
      cadence_raw = 1'b1; step($urandom_range(1, 14));
      cadence_raw = 1'b0; step($urandom_range(1, 20));
    end
    cadence_raw = 1'b0;
    wait_cyc(WIN + 1);
    tot++; if (cadence !== 5'd0) begin bad++; $display("FAIL glitch_cadence: got %0d want 0", cadence); end
    tot++; if (not_pedaling !== 1'b1) begin bad++; $display("FAIL glitch_np: got %b want 1", not_pedaling); end
    tot++; if (rise_err !== base) begin bad++; $display("FAIL glitch_rise: %0d bad strobe clocks, want 0", rise_err - base); end
  endtask

  task automatic test_const_torque();
    do_reset();
    torque = 12'h800;
    step(10);
    for (int i = 0; i < 10; i++) pulse(40, 40);
    wait_cyc(WIN);
    tot++; if (cadence !== 5'd10) begin bad++; $display("FAIL ten_cadence: got %0d want 10", cadence); end
    tot++; if (avg_torque !== 12'h000) begin bad++; $display("FAIL held_avg: got %h want 000", avg_torque); end
    step(1);
    tot++; if (not_pedaling !== 1'b0) begin bad++; $display("FAIL ten_np: got %b want 0", not_pedaling); end
    tot++; if (avg_torque !== 12'h800) begin bad++; $display("FAIL const_preload: got %h want 800", avg_torque); end
    for (int i = 0; i < 5; i++) begin
      pulse(40, 40);
      tot++; if (avg_torque !== 12'h800) begin bad++; $display("FAIL const_avg: got %h want 800", avg_torque); end
    end
  endtask

  task automatic test_step_response();
    do_reset();
    torque = 12'h000;
    step(10);
    for (int i = 0; i < 3; i++) pulse(40, 40);
    wait_cyc(WIN + 1);
    tot++; if (not_pedaling !== 1'b0) begin bad++; $display("FAIL step_np: got %b want 0", not_pedaling); end
    tot++; if (avg_torque !== 12'h000) begin bad++; $display("FAIL step_zero: got %h want 000", avg_torque); end
    torque = 12'h800;
    mono_prev = 12'h000;
    mono_err = 0;
    mono_en = 1'b1;
    for (int i = 0; i < 100; i++) pulse(40, 40);
    mono_en = 1'b0;
    tot++; if (mono_err != 0) begin bad++; $display("FAIL step_mono: %0d decreasing clocks, want 0", mono_err); end
    tot++; if (avg_torque < 12'h7F0 || avg_torque > 12'h800) begin bad++; $display("FAIL step_final: got %h want 7F0..800", avg_torque); end
    tot++; if (32'(avg_torque) != m_acc / 16) begin bad++; $display("FAIL step_model: got %h want %h", avg_torque, m_acc / 16); end
  endtask

  task automatic test_saturate_coincide();
    do_reset();
    torque = 12'h123;
    step(10);
    for (int i = 0; i < 40; i++) pulse(25, 25);
    wait_cyc(WIN);
    tot++; if (cadence !== 5'd31) begin bad++; $display("FAIL saturate: got %0d want 31", cadence); end
    step(10);
    for (int i = 0; i < 10; i++) pulse(40, 40);
    wait_cyc(2 * WIN - LAT);
    cadence_raw = 1'b1;
    sq.push_back(cyc + LAT);
    step(LAT);
    tot++; if (cadence !== 5'd10) begin bad++; $display("FAIL coincide_old: got %0d want 10", cadence); end
    step(20);
    cadence_raw = 1'b0;
    wait_cyc(3 * WIN);
    tot++; if (cadence !== 5'd1) begin bad++; $display("FAIL coincide_new: got %0d want 1", cadence); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    torque = 12'h321;
    step(10);
    for (int i = 0; i < 5; i++) pulse(40, 40);
    cadence_raw = 1'b1;
    step(8);
    rst = 1'b1;
    step(1);
    cadence_raw = 1'b0;
    step(2);
    base = rise_err;
    rst = 1'b0;
    step(1);
    tot++; if (cadence !== 5'd0) begin bad++; $display("FAIL mid_cadence: got %0d want 0", cadence); end
    tot++; if (not_pedaling !== 1'b1) begin bad++; $display("FAIL mid_np: got %b want 1", not_pedaling); end
    wait_cyc(WIN);
    tot++; if (cadence !== 5'd0) begin bad++; $display("FAIL mid_window: got %0d want 0", cadence); end
    tot++; if (rise_err !== base) begin bad++; $display("FAIL mid_rise: %0d bad strobe clocks, want 0", rise_err - base); end
  endtask

  task automatic test_random();
    int base;
    do_reset();
    base = rise_err;
    torque = 12'($urandom_range(0, 4095));
    step(10);
    while (cyc < 2 * WIN + 500) begin
      torque = 12'($urandom_range(0, 4095));
      pulse($urandom_range(18, 60), $urandom_range(20, 200));
      tot++; if (32'(avg_torque) != m_acc / 16) begin bad++; $display("FAIL rnd_avg: got %h want %h at cycle %0d", avg_torque, m_acc / 16, cyc); end
      tot++; if (32'(cadence) != m_cad) begin bad++; $display("FAIL rnd_cadence: got %0d want %0d at cycle %0d", cadence, m_cad, cyc); end
      tot++; if (32'(not_pedaling) != m_np) begin bad++; $display("FAIL rnd_np: got %b want %0d at cycle %0d", not_pedaling, m_np, cyc); end
    end
    tot++; if (rise_err !== base) begin bad++; $display("FAIL rnd_rise: %0d bad strobe clocks, want 0", rise_err - base); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    cadence_raw = 1'b0;
    torque = 12'h000;
    step(2);
    test_reset();
    test_first_window();
    test_glitch();
    test_const_torque();
    test_step_response();
    test_saturate_coincide();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
